// File: rtl/axis_pha_peak.sv
// axis_pha_peak
// Pulse-height peak detector for an AXI-Stream ADC sample stream. Each accepted
// sample is compared with the one before it. A rise followed by the first drop
// marks a peak, and the peak value is the sample taken just before the drop.
// After a peak the detector waits out a dead time. An in-window peak height is
// then offered on the master stream. If the master stream is still holding an
// earlier, unaccepted result, the new result is dropped and counted.
//
// Build option:
//   AXIS_PHA_BASELINE_EN  when defined, cfg_baseline is added and the result
//                         becomes (peak - cfg_baseline). The subtraction is
//                         clamped to the range [0, max positive].
//
// Ports:
//   aclk, aresetn      clock (rising edge), synchronous active-low reset
//   cfg_min, cfg_max   signed inclusive window for accepted results
//   cfg_delay          dead time after a peak, counted in accepted samples
//   cfg_baseline       signed baseline (only with AXIS_PHA_BASELINE_EN)
//   s_axis_*           sample input; always ready while out of reset
//   m_axis_*           peak height output with valid/ready hold semantics
//   sts_drops          saturating count of results lost to a busy output
//
// state | meaning
// IDLE  | waiting for a sample greater than the previous one
// RISE  | signal rising or flat; first drop emits prev as the peak
// DEAD  | dead time after a peak; counts accepted samples down to zero
module axis_pha_peak #(
   parameter int AXIS_TDATA_WIDTH = 16,
   parameter int CNTR_WIDTH       = 16
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic [AXIS_TDATA_WIDTH-1:0] cfg_min,
   input  logic [AXIS_TDATA_WIDTH-1:0] cfg_max,
   input  logic [CNTR_WIDTH-1:0]       cfg_delay,
`ifdef AXIS_PHA_BASELINE_EN
   input  logic [AXIS_TDATA_WIDTH-1:0] cfg_baseline,
`endif
   output logic                        s_axis_tready,
   input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                        s_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
   output logic                        m_axis_tvalid,
   output logic [CNTR_WIDTH-1:0]       sts_drops
);

   localparam int W = AXIS_TDATA_WIDTH;

   typedef enum logic [1:0] {IDLE, RISE, DEAD} state_t;

   state_t                 state;
   logic signed [W-1:0]    cur;
   logic signed [W-1:0]    prev;
   logic                   cur_new;
   logic [CNTR_WIDTH-1:0]  cnt;
   logic [W-1:0]           out_data;
   logic                   out_valid;
   logic [CNTR_WIDTH-1:0]  drops;

   logic                   accept;
   logic                   peak_evt;
   logic                   in_win;
   logic                   emit;
   logic                   hs;
   logic signed [W-1:0]    result;

   assign accept = s_axis_tvalid & aresetn;

`ifdef AXIS_PHA_BASELINE_EN
   localparam logic signed [W:0] MAX_POS = {2'b00, {(W-1){1'b1}}};
   logic signed [W:0] diff;
   always_comb begin
      diff = {prev[W-1], prev} - {cfg_baseline[W-1], cfg_baseline};
      if (diff < 0)
         result = '0;
      else if (diff > MAX_POS)
         result = MAX_POS[W-1:0];
      else
         result = diff[W-1:0];
   end
`else
   assign result = prev;
`endif

   // The FSM works one cycle behind the sample handshake. cur_new marks the cycle
   // in which cur and prev hold a newly accepted pair.
   assign peak_evt = cur_new && (state == RISE) && (cur < prev);
   assign in_win   = (result >= $signed(cfg_min)) && (result <= $signed(cfg_max));
   assign emit     = peak_evt && in_win;
   assign hs       = out_valid & m_axis_tready;

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state     <= IDLE;
         cur       <= '0;
         prev      <= '0;
         cur_new   <= 1'b0;
         cnt       <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         drops     <= '0;
      end else begin
         cur_new <= accept;
         if (accept) begin
            prev <= cur;
            cur  <= s_axis_tdata;
         end

         if (cur_new) begin
            case (state)
               IDLE: if (cur > prev) state <= RISE;
               RISE: if (cur < prev) begin
                  state <= DEAD;
                  cnt   <= cfg_delay;
               end
               DEAD: if (cnt == '0) state <= IDLE;
                     else           cnt   <= cnt - 1'b1;
               default: state <= IDLE;
            endcase
         end

         // A result that lands in the same cycle as a handshake takes the freed slot.
         if (emit) begin
            if (!out_valid || hs) begin
               out_valid <= 1'b1;
               out_data  <= result;
            end else if (drops != '1) begin
               drops <= drops + 1'b1;
            end
         end else if (hs) begin
            out_valid <= 1'b0;
         end
      end
   end

   // The reset is synchronous, so the registers clear only on the next edge.
   // Gating the outputs with aresetn makes them read 0 for the whole time
   // aresetn is low, including the part of the cycle before that edge.
   assign s_axis_tready = aresetn;
   assign m_axis_tvalid = out_valid & aresetn;
   assign m_axis_tdata  = aresetn ? out_data : '0;
   assign sts_drops     = aresetn ? drops : '0;

endmodule

// File: tb/tb_axis_pha_peak.sv
module tb_axis_pha_peak;
   localparam int W = 16;
   localparam int C = 16;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic [W-1:0]  cfg_min = '0, cfg_max = '0;
   logic [C-1:0]  cfg_delay = '0;
   logic [W-1:0]  cfg_baseline = '0;
   logic          s_axis_tready;
   logic [W-1:0]  s_axis_tdata = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          m_axis_tready = 1'b0;
   logic [W-1:0]  m_axis_tdata;
   logic          m_axis_tvalid;
   logic [C-1:0]  sts_drops;

   always #5 aclk = ~aclk;

   axis_pha_peak #(.AXIS_TDATA_WIDTH(W), .CNTR_WIDTH(C)) dut (
      .aclk(aclk),
      .aresetn(aresetn),
      .cfg_min(cfg_min),
      .cfg_max(cfg_max),
      .cfg_delay(cfg_delay),
`ifdef AXIS_PHA_BASELINE_EN
      .cfg_baseline(cfg_baseline),
`endif
      .s_axis_tready(s_axis_tready),
      .s_axis_tdata(s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tdata(m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .sts_drops(sts_drops)
   );

   int n_pass = 0;
   int n_total = 0;

   // Reference model: sample-level peak finder plus a one-slot output buffer.
   int md_prev;
   bit md_rising;
   int md_dead;        // -1 = not in dead time, else samples remaining
   bit pend_v;
   int pend_r;
   bit mv;
   int mdata;
   int mdrops;

   function automatic int sx(input logic [W-1:0] v);
      return int'($signed(v));
   endfunction

   function automatic int result_of(input int peak);
`ifdef AXIS_PHA_BASELINE_EN
      int r;
      r = peak - sx(cfg_baseline);
      if (r < 0) r = 0;
      if (r > 32767) r = 32767;
      return r;
`else
      return peak;
`endif
   endfunction

   task automatic model_reset();
      md_prev = 0; md_rising = 0; md_dead = -1;
      pend_v = 0; pend_r = 0; mv = 0; mdata = 0; mdrops = 0;
   endtask

   task automatic tick(input bit v, input int d, input bit r);
      bit hs;
      bit win;
      s_axis_tvalid = v;
      s_axis_tdata  = 16'(d);
      m_axis_tready = r;
      @(posedge aclk);
      if (!aresetn) begin
         model_reset();
      end else begin
         hs  = mv && r;
         win = pend_v && pend_r >= sx(cfg_min) && pend_r <= sx(cfg_max);
         if (win) begin
            if (!mv || hs) begin mv = 1; mdata = pend_r; end
            else if (mdrops < 65535) mdrops++;
         end else if (hs) mv = 0;
         pend_v = 0;
         if (v) begin
            if (md_dead >= 0) begin
               md_dead = (md_dead == 0) ? -1 : md_dead - 1;
            end else if (md_rising) begin
               if (d < md_prev) begin
                  pend_v = 1; pend_r = result_of(md_prev);
                  md_rising = 0; md_dead = int'(cfg_delay);
               end
            end else if (d > md_prev) md_rising = 1;
            md_prev = d;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      aresetn = 0;
      tick(0, 0, 1);
      tick(0, 0, 1);
      aresetn = 1;
   endtask

   task automatic test_reset();
      aresetn = 0;
      tick(0, 0, 0);
      tick(0, 0, 0);
      n_total++; if (s_axis_tready !== 1'b0) $display("FAIL reset_tready: got %b want 0", s_axis_tready); else n_pass++;
      n_total++; if (m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); else n_pass++;
      n_total++; if (m_axis_tdata !== '0) $display("FAIL reset_tdata: got %0d want 0", m_axis_tdata); else n_pass++;
      n_total++; if (sts_drops !== '0) $display("FAIL reset_drops: got %0d want 0", sts_drops); else n_pass++;
      aresetn = 1;
      #1;
      n_total++; if (s_axis_tready !== 1'b1) $display("FAIL run_tready: got %b want 1", s_axis_tready); else n_pass++;
   endtask

   task automatic test_basic();
      int s[6] = '{0, 10, 20, 30, 20, 10};
      int outs = 0;
      cfg_min = 16'd5; cfg_max = 16'd100; cfg_delay = '0;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         tick(1, s[i], 1);
         if (m_axis_tvalid === 1'b1) outs++;
         if (i == 5) begin
            n_total++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'd30)
               $display("FAIL basic_out: got v=%b d=%0d want v=1 d=30", m_axis_tvalid, m_axis_tdata); else n_pass++;
         end
      end
      for (int i = 0; i < 4; i++) begin
         tick(0, 0, 1);
         if (m_axis_tvalid === 1'b1) outs++;
      end
      n_total++; if (outs != 1) $display("FAIL basic_count: got %0d want 1", outs); else n_pass++;
   endtask

   task automatic test_window();
      int s[6] = '{0, 10, 20, 30, 20, 10};
      int outs = 0;
      cfg_min = 16'd5; cfg_max = 16'd25; cfg_delay = '0;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         tick(i < 6, (i < 6) ? s[i] : 0, 1);
         if (m_axis_tvalid === 1'b1) outs++;
      end
      n_total++; if (outs != 0) $display("FAIL window_count: got %0d want 0", outs); else n_pass++;
      n_total++; if (sts_drops !== '0) $display("FAIL window_drops: got %0d want 0", sts_drops); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int s[11] = '{0, 10, 20, 30, 20, 10, 20, 40, 30, 20, 10};
      cfg_min = 16'd5; cfg_max = 16'd100; cfg_delay = '0;
      do_reset();
      for (int i = 0; i < 11; i++) tick(1, s[i], 0);
      tick(0, 0, 0);
      n_total++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'd30)
         $display("FAIL hold_out: got v=%b d=%0d want v=1 d=30", m_axis_tvalid, m_axis_tdata); else n_pass++;
      n_total++; if (sts_drops !== 16'd1) $display("FAIL hold_drops: got %0d want 1", sts_drops); else n_pass++;
      tick(0, 0, 1);
      n_total++; if (m_axis_tvalid !== 1'b0) $display("FAIL hold_release: got %b want 0", m_axis_tvalid); else n_pass++;
   endtask

   task automatic test_dead_time();
      int s[11] = '{0, 10, 20, 30, 20, 25, 35, 20, 10, 5, 0};
      int outs = 0;
      int first = -1;
      cfg_min = 16'd5; cfg_max = 16'd100; cfg_delay = 16'd5;
      do_reset();
      for (int i = 0; i < 14; i++) begin
         tick(i < 11, (i < 11) ? s[i] : 0, 1);
         if (m_axis_tvalid === 1'b1) begin
            outs++;
            if (first < 0) first = int'(m_axis_tdata);
         end
      end
      n_total++; if (outs != 1) $display("FAIL dead_count: got %0d want 1", outs); else n_pass++;
      n_total++; if (first != 30) $display("FAIL dead_value: got %0d want 30", first); else n_pass++;
   endtask

   task automatic test_inverted_window();
      int outs = 0;
      cfg_min = 16'd100; cfg_max = 16'd5; cfg_delay = '0;
      do_reset();
      for (int i = 0; i < 200; i++) begin
         tick(1, int'($urandom_range(0, 150)), 1);
         if (m_axis_tvalid === 1'b1) outs++;
      end
      n_total++; if (outs != 0) $display("FAIL inverted_count: got %0d want 0", outs); else n_pass++;
   endtask

   task automatic test_reset_mid_rise();
      int tail[4] = '{-5, -10, -10, -20};
      int pulse[5] = '{0, 10, 30, 10, 0};
      int outs = 0;
      cfg_min = 16'd5; cfg_max = 16'd100; cfg_delay = '0;
      do_reset();
      tick(1, 0, 1); tick(1, 10, 1); tick(1, 20, 1);
      aresetn = 0;
      #1;
      n_total++; if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || sts_drops !== '0)
         $display("FAIL midrst_outs: got r=%b v=%b d=%0d dr=%0d want all 0", s_axis_tready, m_axis_tvalid, m_axis_tdata, sts_drops); else n_pass++;
      tick(1, 25, 1);
      aresetn = 1;
      for (int i = 0; i < 6; i++) begin
         tick(i < 4, (i < 4) ? tail[i] : 0, 1);
         if (m_axis_tvalid === 1'b1) outs++;
      end
      n_total++; if (outs != 0) $display("FAIL midrst_count: got %0d want 0", outs); else n_pass++;
      outs = 0;
      for (int i = 0; i < 7; i++) begin
         tick(i < 5, (i < 5) ? pulse[i] : 0, 1);
         if (m_axis_tvalid === 1'b1 && m_axis_tdata === 16'd30) outs++;
      end
      n_total++; if (outs != 1) $display("FAIL midrst_recover: got %0d want 1", outs); else n_pass++;
   endtask

`ifdef AXIS_PHA_BASELINE_EN
   task automatic test_baseline();
      int a[6] = '{0, 10, 20, 30, 20, 10};
      int b[5] = '{0, 4, 8, 4, 0};
      int got = -1;
      cfg_baseline = 16'd12; cfg_min = 16'd0; cfg_max = 16'd100; cfg_delay = '0;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         tick(i < 6, (i < 6) ? a[i] : 0, 1);
         if (m_axis_tvalid === 1'b1) got = int'(m_axis_tdata);
      end
      n_total++; if (got != 18) $display("FAIL base_30: got %0d want 18", got); else n_pass++;
      got = -1;
      do_reset();
      for (int i = 0; i < 7; i++) begin
         tick(i < 5, (i < 5) ? b[i] : 0, 1);
         if (m_axis_tvalid === 1'b1) got = int'(m_axis_tdata);
      end
      n_total++; if (got != 0) $display("FAIL base_clamp0: got %0d want 0", got); else n_pass++;
      cfg_baseline = 16'hFFF4; cfg_max = 16'h7FFF;
      got = -1;
      do_reset();
      tick(1, 0, 1); tick(1, 32767, 1); tick(1, 0, 1); tick(0, 0, 1);
      if (m_axis_tvalid === 1'b1) got = int'(m_axis_tdata);
      n_total++; if (got != 32767) $display("FAIL base_clampmax: got %0d want 32767", got); else n_pass++;
      cfg_baseline = '0;
   endtask
`endif

   task automatic test_random();
      int mn, mx;
      for (int round = 0; round < 4; round++) begin
         mn = int'($urandom_range(0, 70)) - 20;
         mx = int'($urandom_range(50, 180));
         cfg_min = 16'(mn); cfg_max = 16'(mx);
         cfg_delay = 16'($urandom_range(0, 4));
         do_reset();
         for (int i = 0; i < 800; i++) begin
            tick($urandom_range(0, 3) != 0, int'($urandom_range(0, 250)) - 50, $urandom_range(0, 9) < 6);
            n_total++; if (m_axis_tvalid !== mv)
               $display("FAIL rnd_valid: cyc %0d got %b want %b", i, m_axis_tvalid, mv); else n_pass++;
            if (mv) begin
               n_total++; if (sx(m_axis_tdata) != mdata)
                  $display("FAIL rnd_data: cyc %0d got %0d want %0d", i, sx(m_axis_tdata), mdata); else n_pass++;
            end
            n_total++; if (int'(sts_drops) != mdrops)
               $display("FAIL rnd_drops: cyc %0d got %0d want %0d", i, sts_drops, mdrops); else n_pass++;
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_window();
      test_back_to_back();
      test_dead_time();
      test_inverted_window();
      test_reset_mid_rise();
`ifdef AXIS_PHA_BASELINE_EN
      test_baseline();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
